// File: rtl/cdb_arbiter_if.sv
// FU-result / CDB-broadcast bundle shared by the arbiter and its requesters.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                  i_flush;
  logic [NUM_FU-1:0]     i_fu_valid;
  logic [NUM_FU-1:0]     i_fu_redirect;
  logic [DATA_WIDTH-1:0] i_fu_data [NUM_FU];
  logic [ADDR_WIDTH-1:0] i_fu_addr [NUM_FU];
  logic [TAG_WIDTH-1:0]  i_fu_tag  [NUM_FU];
  logic [NUM_FU-1:0]     o_fu_stall;
  logic                  o_cdb_en;
  logic                  o_cdb_redirect;
  logic [DATA_WIDTH-1:0] o_cdb_data;
  logic [ADDR_WIDTH-1:0] o_cdb_addr;
  logic [TAG_WIDTH-1:0]  o_cdb_tag;

  modport master (
    output i_flush, i_fu_valid, i_fu_redirect, i_fu_data, i_fu_addr, i_fu_tag,
    input  o_fu_stall, o_cdb_en, o_cdb_redirect, o_cdb_data, o_cdb_addr, o_cdb_tag
  );

  modport slave (
    input  i_flush, i_fu_valid, i_fu_redirect, i_fu_data, i_fu_addr, i_fu_tag,
    output o_fu_stall, o_cdb_en, o_cdb_redirect, o_cdb_data, o_cdb_addr, o_cdb_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one CDB lane among NUM_FU functional units.
// Latency 1 cycle to o_cdb_*; losers get a same-cycle stall and must hold, nothing is buffered.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  cdb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_FU);

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     scan_idx;
  logic [PW-1:0]     grant_idx;
  logic              grant_vld;
  logic [NUM_FU-1:0] grant;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_FU) s = s - NUM_FU;
    return PW'(s);
  endfunction

  // First valid FU at or after rr_ptr wins; flush suppresses the grant entirely.
  always_comb begin
    scan_idx  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan_idx = wrap_idx(rr_ptr, i);
      if (!grant_vld && bus.i_fu_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (bus.i_flush) grant_vld = 1'b0;
    grant[grant_idx] = grant_vld;
  end

  assign bus.o_fu_stall = bus.i_fu_valid & ~grant & {NUM_FU{~bus.i_flush}};

  // Payload fields hold across idle cycles; consumers qualify with o_cdb_en.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr_ptr             <= '0;
      bus.o_cdb_en       <= 1'b0;
      bus.o_cdb_redirect <= 1'b0;
      bus.o_cdb_data     <= '0;
      bus.o_cdb_addr     <= '0;
      bus.o_cdb_tag      <= '0;
    end else begin
      bus.o_cdb_en <= grant_vld;
      if (grant_vld) begin
        bus.o_cdb_redirect <= bus.i_fu_redirect[grant_idx];
        bus.o_cdb_data     <= bus.i_fu_data[grant_idx];
        bus.o_cdb_addr     <= bus.i_fu_addr[grant_idx];
        bus.o_cdb_tag      <= bus.i_fu_tag[grant_idx];
        rr_ptr             <= (grant_idx == PW'(NUM_FU - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then constrained-random traffic.
module tb_cdb_arbiter;
  localparam int NUM_FU = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 6;

  typedef struct packed {
    logic          en;
    logic          red;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
  } beat_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int mptr = 0;
  beat_t last_exp = '0;
  beat_t exp_q[$];
  logic [NUM_FU-1:0] last_stall = '0;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_fu(input int k, input logic v, input logic red,
                        input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [TW-1:0] t);
    bus.i_fu_valid[k]    = v;
    bus.i_fu_redirect[k] = red;
    bus.i_fu_data[k]     = d;
    bus.i_fu_addr[k]     = a;
    bus.i_fu_tag[k]      = t;
  endtask

  task automatic set_default_payloads(input logic [NUM_FU-1:0] v);
    for (int k = 0; k < NUM_FU; k++)
      set_fu(k, v[k], 1'b0, 32'hA000_0000 + DW'(k), 32'h100 * AW'(k), TW'(8 + k));
  endtask

  // One clock: check same-cycle stalls, predict the next broadcast, compare at the next negedge.
  task automatic step();
    int g;
    int k;
    logic [NUM_FU-1:0] onehot;
    logic [NUM_FU-1:0] exp_stall;
    beat_t e;
    beat_t got;
    #1;
    g = -1;
    onehot = '0;
    if (!bus.i_flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        k = (mptr + i) % NUM_FU;
        if (g < 0 && bus.i_fu_valid[k]) g = k;
      end
    end
    if (g >= 0) onehot[g] = 1'b1;
    exp_stall = bus.i_fu_valid & ~onehot & {NUM_FU{~bus.i_flush}};
    chk("stall", 64'(bus.o_fu_stall), 64'(exp_stall));
    last_stall = exp_stall;
    if (!n_rst) begin
      e = '0;
      mptr = 0;
    end else if (g >= 0) begin
      e.en   = 1'b1;
      e.red  = bus.i_fu_redirect[g];
      e.data = bus.i_fu_data[g];
      e.addr = bus.i_fu_addr[g];
      e.tag  = bus.i_fu_tag[g];
      mptr   = (g + 1) % NUM_FU;
    end else begin
      e = last_exp;
      e.en = 1'b0;
    end
    last_exp = e;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      got.en   = bus.o_cdb_en;
      got.red  = bus.o_cdb_redirect;
      got.data = bus.o_cdb_data;
      got.addr = bus.o_cdb_addr;
      got.tag  = bus.o_cdb_tag;
      chk("cdb_en", 64'(got.en), 64'(e.en));
      chk("cdb_redirect", 64'(got.red), 64'(e.red));
      chk("cdb_data", 64'(got.data), 64'(e.data));
      chk("cdb_addr", 64'(got.addr), 64'(e.addr));
      chk("cdb_tag", 64'(got.tag), 64'(e.tag));
    end
  endtask

  initial begin
    bus.i_flush = 1'b0;
    set_default_payloads(4'b1111);
    repeat (2) @(negedge clk);

    // Reset held with every FU requesting: outputs stay zero.
    repeat (3) step();
    chk("rst_ptr", 64'(dut.rr_ptr), 64'd0);

    // Release: FU0 first, then strict rotation with all four held valid.
    n_rst = 1'b1;
    step();
    chk("first_grant_tag", 64'(bus.o_cdb_tag), 64'd8);
    repeat (4) step();
    chk("rotate_tag", 64'(bus.o_cdb_tag), 64'd8);

    // Lone FU1 moves the pointer to 2, then lone FU1 again at rr_ptr=2.
    set_default_payloads(4'b0010);
    step();
    chk("ptr_after_fu1", 64'(dut.rr_ptr), 64'd2);
    set_fu(1, 1'b1, 1'b0, 32'hDEAD, 32'h0, 6'h05);
    step();
    chk("lone_tag", 64'(bus.o_cdb_tag), 64'h05);
    chk("lone_data", 64'(bus.o_cdb_data), 64'hDEAD);
    chk("lone_ptr", 64'(dut.rr_ptr), 64'd2);

    // Wrap: rr_ptr=3 with FU0 and FU3 valid.
    set_default_payloads(4'b0100);
    step();
    set_default_payloads(4'b1001);
    step();
    chk("wrap_tag", 64'(bus.o_cdb_tag), 64'd11);
    chk("wrap_ptr", 64'(dut.rr_ptr), 64'd0);
    set_default_payloads(4'b0001);
    step();
    chk("wrap_next_tag", 64'(bus.o_cdb_tag), 64'd8);

    // Flush with FU1 and FU2 valid.
    set_default_payloads(4'b0110);
    bus.i_flush = 1'b1;
    step();
    chk("flush_en", 64'(bus.o_cdb_en), 64'd0);
    chk("flush_ptr", 64'(dut.rr_ptr), 64'd1);
    bus.i_flush = 1'b0;

    // Idle cycle holds the previous payload.
    set_default_payloads(4'b0000);
    step();

    // Redirect pass-through from FU2.
    set_fu(2, 1'b1, 1'b1, 32'h77, 32'h1000, 6'h2A);
    step();
    chk("redir_flag", 64'(bus.o_cdb_redirect), 64'd1);
    chk("redir_addr", 64'(bus.o_cdb_addr), 64'h1000);

    // Reset in the middle of a stall sequence restarts at FU0.
    set_default_payloads(4'b1111);
    step();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    chk("rst_mid_tag", 64'(bus.o_cdb_tag), 64'd8);

    // Random traffic; stalled FUs keep their request and payload.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (!last_stall[k])
          set_fu(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom), AW'($urandom), TW'($urandom));
      end
      bus.i_flush = ($urandom_range(0, 15) == 0);
      n_rst = ($urandom_range(0, 63) != 0);
      step();
    end
    n_rst = 1'b1;
    bus.i_flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
